// File: rtl/uart_pkg.sv
// Shared encodings, FSM states and the parity helper for the UART core.
package uart_pkg;

  localparam int PAR_NONE = 0;
  localparam int PAR_EVEN = 1;
  localparam int PAR_ODD  = 2;

  typedef enum logic [2:0] {
    TX_IDLE, TX_START, TX_DATA, TX_PARITY, TX_STOP
  } tx_state_e;

  typedef enum logic [2:0] {
    RX_IDLE, RX_START, RX_DATA, RX_PARITY, RX_STOP
  } rx_state_e;

  // Callers zero-extend narrower payloads; the extra zeros do not change the XOR.
  function automatic logic parity_bit(input logic [8:0] data, input int mode);
    return (^data) ^ (mode == PAR_ODD);
  endfunction

endpackage

// File: rtl/uart_core_param_if.sv
// Byte-level handshake bundle between the UART and its bus-side user.
interface uart_core_param_if #(
  parameter int DATA_BITS = 8
);
  logic [DATA_BITS-1:0] tx_data;
  logic                 tx_valid;
  logic                 tx_ready;
  logic [DATA_BITS-1:0] rx_data;
  logic                 rx_valid;
  logic                 rx_ready;
  logic                 rx_frame_err;
  logic                 rx_parity_err;
  logic                 rx_overrun;

  modport master (
    output tx_data, tx_valid, rx_ready,
    input  tx_ready, rx_data, rx_valid, rx_frame_err, rx_parity_err, rx_overrun
  );

  modport slave (
    input  tx_data, tx_valid, rx_ready,
    output tx_ready, rx_data, rx_valid, rx_frame_err, rx_parity_err, rx_overrun
  );
endinterface

// File: rtl/uart_tick_gen.sv
// Oversample clock-enable: one-cycle tick every CLK_DIV sysclk cycles.
module uart_tick_gen #(
  parameter int CLK_DIV = 27
) (
  input  logic clk_i,
  input  logic rst_i,
  output logic tick_o
);
  localparam int CW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

  logic [CW-1:0] cnt_q;

  assign tick_o = (cnt_q == CW'(CLK_DIV - 1));

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i)       cnt_q <= '0;
    else if (tick_o) cnt_q <= '0;
    else             cnt_q <= cnt_q + 1'b1;
  end
endmodule

// File: rtl/uart_core_param.sv
// Full-duplex UART on a single clock: TX and RX FSMs advanced by a shared oversample tick.
// TX bit timing counts OVERSAMPLE ticks per bit; RX samples mid-bit after a 2-FF synchroniser.
module uart_core_param
  import uart_pkg::*;
#(
  parameter int CLK_DIV    = 27,
  parameter int OVERSAMPLE = 16,
  parameter int DATA_BITS  = 8,
  parameter int PARITY     = 0,
  parameter int STOP_BITS  = 1
) (
  input  logic             sysclk,
  input  logic             reset,
  input  logic             rxd,
  output logic             txd,
  uart_core_param_if.slave bus
);
  localparam int PW = $clog2(OVERSAMPLE);
  localparam logic [PW-1:0] PH_LAST = PW'(OVERSAMPLE - 1);
  localparam logic [PW-1:0] PH_MID  = PW'(OVERSAMPLE / 2 - 1);

  logic tick;

  uart_tick_gen #(.CLK_DIV(CLK_DIV)) u_tick (
    .clk_i  (sysclk),
    .rst_i  (reset),
    .tick_o (tick)
  );

  tx_state_e            tx_state_q;
  logic [PW-1:0]        tx_phase_q;
  logic [3:0]           tx_bit_q;
  logic                 tx_stop_q;
  logic [DATA_BITS-1:0] tx_shift_q;
  logic                 tx_par_q;
  logic                 tx_txd_q;
  logic                 tx_bit_end, tx_done, tx_accept;

  assign tx_bit_end   = tick && (tx_phase_q == PH_LAST);
  assign tx_done      = (tx_state_q == TX_STOP) && tx_bit_end && (tx_stop_q == 1'(STOP_BITS - 1));
  // Ready during the final stop cycle lets the next frame start with no idle gap.
  assign bus.tx_ready = (tx_state_q == TX_IDLE) || tx_done;
  assign tx_accept    = bus.tx_valid && bus.tx_ready;
  assign txd          = tx_txd_q;

  always_ff @(posedge sysclk or posedge reset) begin
    if (reset) begin
      tx_state_q <= TX_IDLE;
      tx_phase_q <= '0;
      tx_bit_q   <= '0;
      tx_stop_q  <= 1'b0;
      tx_shift_q <= '0;
      tx_par_q   <= 1'b0;
      tx_txd_q   <= 1'b1;
    end else begin
      if (tick && tx_state_q != TX_IDLE)
        tx_phase_q <= tx_bit_end ? '0 : tx_phase_q + 1'b1;
      if (tx_accept) begin
        tx_state_q <= TX_START;
        tx_phase_q <= '0;
        tx_shift_q <= bus.tx_data;
        tx_par_q   <= parity_bit(9'(bus.tx_data), PARITY);
        tx_txd_q   <= 1'b0;
      end else if (tx_bit_end) begin
        case (tx_state_q)
          TX_START: begin
            tx_state_q <= TX_DATA;
            tx_bit_q   <= '0;
            tx_txd_q   <= tx_shift_q[0];
            tx_shift_q <= tx_shift_q >> 1;
          end
          TX_DATA: begin
            if (tx_bit_q == 4'(DATA_BITS - 1)) begin
              if (PARITY != PAR_NONE) begin
                tx_state_q <= TX_PARITY;
                tx_txd_q   <= tx_par_q;
              end else begin
                tx_state_q <= TX_STOP;
                tx_stop_q  <= 1'b0;
                tx_txd_q   <= 1'b1;
              end
            end else begin
              tx_bit_q   <= tx_bit_q + 1'b1;
              tx_txd_q   <= tx_shift_q[0];
              tx_shift_q <= tx_shift_q >> 1;
            end
          end
          TX_PARITY: begin
            tx_state_q <= TX_STOP;
            tx_stop_q  <= 1'b0;
            tx_txd_q   <= 1'b1;
          end
          TX_STOP: begin
            if (tx_done) tx_state_q <= TX_IDLE;
            else         tx_stop_q  <= tx_stop_q + 1'b1;
          end
          default: ;
        endcase
      end
    end
  end

  logic                 rx_s1_q, rx_s2_q;
  rx_state_e            rx_state_q;
  logic [PW-1:0]        rx_phase_q;
  logic [3:0]           rx_bit_q;
  logic [DATA_BITS-1:0] rx_shift_q;
  logic                 rx_par_q, rx_brk_q;
  logic [DATA_BITS-1:0] rx_data_q;
  logic                 rx_valid_q, rx_ferr_q, rx_perr_q, rx_ovr_q;
  logic                 rx_sample, rx_consume;

  always_ff @(posedge sysclk or posedge reset) begin
    if (reset) begin
      rx_s1_q <= 1'b1;
      rx_s2_q <= 1'b1;
    end else begin
      rx_s1_q <= rxd;
      rx_s2_q <= rx_s1_q;
    end
  end

  assign rx_sample  = (rx_state_q == RX_START) ? (rx_phase_q == PH_MID) : (rx_phase_q == PH_LAST);
  assign rx_consume = rx_valid_q && bus.rx_ready;

  always_ff @(posedge sysclk or posedge reset) begin
    if (reset) begin
      rx_state_q <= RX_IDLE;
      rx_phase_q <= '0;
      rx_bit_q   <= '0;
      rx_shift_q <= '0;
      rx_par_q   <= 1'b0;
      rx_brk_q   <= 1'b0;
      rx_data_q  <= '0;
      rx_valid_q <= 1'b0;
      rx_ferr_q  <= 1'b0;
      rx_perr_q  <= 1'b0;
      rx_ovr_q   <= 1'b0;
    end else begin
      rx_ovr_q <= 1'b0;
      if (rx_consume) rx_valid_q <= 1'b0;
      if (rx_state_q == RX_IDLE) begin
        // After a break, start detection re-arms only once the line has gone high.
        if (rx_brk_q) begin
          if (rx_s2_q) rx_brk_q <= 1'b0;
        end else if (tick && !rx_s2_q) begin
          rx_state_q <= RX_START;
          rx_phase_q <= '0;
        end
      end else if (tick) begin
        if (!rx_sample) begin
          rx_phase_q <= rx_phase_q + 1'b1;
        end else begin
          rx_phase_q <= '0;
          case (rx_state_q)
            RX_START: begin
              if (rx_s2_q) rx_state_q <= RX_IDLE;
              else begin
                rx_state_q <= RX_DATA;
                rx_bit_q   <= '0;
              end
            end
            RX_DATA: begin
              rx_shift_q <= {rx_s2_q, rx_shift_q[DATA_BITS-1:1]};
              rx_bit_q   <= rx_bit_q + 1'b1;
              if (rx_bit_q == 4'(DATA_BITS - 1))
                rx_state_q <= (PARITY != PAR_NONE) ? RX_PARITY : RX_STOP;
            end
            RX_PARITY: begin
              rx_par_q   <= rx_s2_q;
              rx_state_q <= RX_STOP;
            end
            RX_STOP: begin
              rx_state_q <= RX_IDLE;
              rx_brk_q   <= !rx_s2_q;
              if (!rx_valid_q || rx_consume) begin
                rx_data_q  <= rx_shift_q;
                rx_ferr_q  <= !rx_s2_q;
                rx_perr_q  <= (PARITY != PAR_NONE) &&
                              (rx_par_q != parity_bit(9'(rx_shift_q), PARITY));
                rx_valid_q <= 1'b1;
              end else begin
                rx_ovr_q <= 1'b1;
              end
            end
            default: rx_state_q <= RX_IDLE;
          endcase
        end
      end
    end
  end

  assign bus.rx_data       = rx_data_q;
  assign bus.rx_valid      = rx_valid_q;
  assign bus.rx_frame_err  = rx_ferr_q;
  assign bus.rx_parity_err = rx_perr_q;
  assign bus.rx_overrun    = rx_ovr_q;
endmodule
